ddr4_v2_2_20_r_unpacker: RTL and testbench
==========================================

DDR4_V2_2_20_R_UNPACKER -- requirements
Module: ddr4_v2_2_20_r_unpacker

Interface
REQ-001 SHALL have parameter C_FAMILY, default "virtex6", target FPGA family string (no functional effect).
REQ-002 SHALL have parameter C_S_DATA_WIDTH, default 32, narrow SI data width; legal values are 32 and 64.
REQ-003 SHALL have parameter C_M_DATA_WIDTH, default 128, wide MI data width; legal values are 128, 256 and 512; RATIO = C_M_DATA_WIDTH/C_S_DATA_WIDTH, a power of 2 >= 2.
REQ-004 SHALL have one clock and an asynchronous active-low reset: ports ACLK (input, 1, clock) and ARESETN (input, 1, async active-low reset).
REQ-005 ACLK  input  1  clock; all state changes on its rising edge.
REQ-006 ARESETN  input  1  asynchronous active-low reset.
REQ-007 CMD_VALID  input  1  burst command valid.
REQ-008 CMD_READY  output  1  command accepted when high with CMD_VALID.
REQ-009 CMD_OFFSET  input  log2(RATIO)  starting narrow lane within the first wide beat.
REQ-010 CMD_LEN  input  8  SI beat count minus 1.
REQ-011 M_RDATA/M_RRESP/M_RLAST/M_RVALID  input  C_M_DATA_WIDTH/2/1/1  wide read beat from the memory side.
REQ-012 M_RREADY  output  1  wide beat accept.
REQ-013 S_RDATA/S_RRESP/S_RLAST/S_RVALID  output  C_S_DATA_WIDTH/2/1/1  narrow read beat to the master.
REQ-014 S_RREADY  input  1  narrow beat accept.
REQ-015 LAST_ERR  output  1  one-cycle pulse flagging an M_RLAST/CMD_LEN mismatch.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD and DRAIN; CMD_READY=(IDLE), M_RREADY=(LOAD), S_RVALID=(DRAIN); all three outputs SHALL be driven from registered state.
REQ-017 IDLE: on CMD_VALID&CMD_READY, latch lane<=CMD_OFFSET, len<=CMD_LEN and beat_cnt<=0, then go to LOAD.
REQ-018 LOAD: on M_RVALID, capture M_RDATA, M_RRESP and M_RLAST into the holding register, then go to DRAIN; with no M_RVALID, remain in LOAD.
REQ-019 DRAIN: S_RDATA=hold[lane*C_S_DATA_WIDTH +: C_S_DATA_WIDTH]; S_RRESP=held RRESP; S_RLAST=(beat_cnt==len).
REQ-020 DRAIN, on S_RVALID&S_RREADY: beat_cnt increments.
REQ-021 Same DRAIN handshake: if S_RLAST=1, go to IDLE.
REQ-022 Same DRAIN handshake, S_RLAST=0 and lane==RATIO-1: lane wraps to 0 and the FSM goes to LOAD.
REQ-023 Same DRAIN handshake, otherwise: lane increments and the FSM stays in DRAIN.
REQ-024 S_RDATA, S_RRESP and S_RLAST SHALL stay stable while S_RVALID=1 and S_RREADY=0.
REQ-025 Latency: first S_RVALID SHALL occur 1 cycle after the M_RVALID&M_RREADY handshake; each wide refill costs exactly one bubble cycle (LOAD).
REQ-026 The wide-beat count consumed per burst SHALL be ceil((CMD_OFFSET+CMD_LEN+1)/RATIO).
REQ-027 LAST_ERR SHALL pulse 1 cycle after the S_RLAST handshake when the held M_RLAST=0.
REQ-028 LAST_ERR SHALL pulse 1 cycle after any wide capture with M_RLAST=1 whose burst still needs further wide beats.
REQ-029 On a LAST_ERR condition the FSM SHALL continue as if no error occurred, with no recovery action.
REQ-030 CMD_LEN=0 SHALL produce exactly one SI beat, with S_RLAST=1.
REQ-031 CMD_LEN=255 SHALL produce 256 SI beats; beat_cnt SHALL be 8 bits and never overflow within a burst.
REQ-032 A new command SHALL be accepted no earlier than the cycle after the last SI handshake (IDLE re-entry); commands SHALL NOT overlap.

Reset
REQ-033 While ARESETN=0: state=IDLE, CMD_READY=0, M_RREADY=0, S_RVALID=0, S_RLAST=0, LAST_ERR=0, lane=0, beat_cnt=0.
REQ-034 The first cycle after ARESETN deasserts, CMD_READY SHALL be 1.
REQ-035 Reset mid-burst SHALL abandon the burst immediately, with no partial S beats after release.
REQ-036 Holding-register data need not be reset.

Verification
REQ-037 Default params, CMD_OFFSET=0, CMD_LEN=7, two wide beats with M_RLAST on the 2nd -> 8 S beats of lanes 0..3, 0..3; S_RLAST on beat 8; 2 M_RREADY handshakes; LAST_ERR=0.
REQ-038 CMD_OFFSET=3, CMD_LEN=1 -> S beats = lane3 of wide beat 0, then lane0 of wide beat 1; 2 wide beats consumed.
REQ-039 CMD_LEN=0, CMD_OFFSET=2, M_RRESP=2'b10 -> single S beat = lane 2, S_RRESP=2'b10, S_RLAST=1; back to IDLE.
REQ-040 S_RREADY held low 5 cycles mid-burst -> S_RDATA, S_RRESP and S_RLAST unchanged; M_RREADY stays 0.
REQ-041 CMD_LEN=7 with M_RLAST=1 on the first wide beat -> LAST_ERR pulses once; 8 S beats still produced.
REQ-042 ARESETN pulsed low during DRAIN of beat 3 -> all outputs 0 during reset; CMD_READY=1 one cycle after release; no stale S_RVALID.

Source files
------------

// File: rtl/ddr4_v2_2_20_r_unpacker_if.sv
// Read-channel bundle for the wide-to-narrow read unpacker: command,
// wide (memory-side) R beat, narrow (master-side) R beat and error flag.
interface ddr4_v2_2_20_r_unpacker_if #(
  parameter int C_S_DATA_WIDTH = 32,
  parameter int C_M_DATA_WIDTH = 128
);
  localparam int RATIO = C_M_DATA_WIDTH / C_S_DATA_WIDTH;
  localparam int OFF_W = $clog2(RATIO);

  logic                      CMD_VALID;
  logic                      CMD_READY;
  logic [OFF_W-1:0]          CMD_OFFSET;
  logic [7:0]                CMD_LEN;

  logic [C_M_DATA_WIDTH-1:0] M_RDATA;
  logic [1:0]                M_RRESP;
  logic                      M_RLAST;
  logic                      M_RVALID;
  logic                      M_RREADY;

  logic [C_S_DATA_WIDTH-1:0] S_RDATA;
  logic [1:0]                S_RRESP;
  logic                      S_RLAST;
  logic                      S_RVALID;
  logic                      S_RREADY;

  logic                      LAST_ERR;

  // Unpacker side
  modport slave (
    input  CMD_VALID, CMD_OFFSET, CMD_LEN,
    input  M_RDATA, M_RRESP, M_RLAST, M_RVALID,
    input  S_RREADY,
    output CMD_READY, M_RREADY,
    output S_RDATA, S_RRESP, S_RLAST, S_RVALID,
    output LAST_ERR
  );

  // Environment side (command source, memory, narrow master)
  modport master (
    output CMD_VALID, CMD_OFFSET, CMD_LEN,
    output M_RDATA, M_RRESP, M_RLAST, M_RVALID,
    output S_RREADY,
    input  CMD_READY, M_RREADY,
    input  S_RDATA, S_RRESP, S_RLAST, S_RVALID,
    input  LAST_ERR
  );
endinterface

// File: rtl/ddr4_v2_2_20_r_unpacker.sv
// Wide-to-narrow read data unpacker. Accepts one burst command, pulls wide
// read beats one at a time and emits them as narrow lanes, starting at the
// commanded lane offset, until CMD_LEN+1 narrow beats have been delivered.
module ddr4_v2_2_20_r_unpacker #(
  parameter     C_FAMILY       = "virtex6",
  parameter int C_S_DATA_WIDTH = 32,
  parameter int C_M_DATA_WIDTH = 128
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  ddr4_v2_2_20_r_unpacker_if.slave bus
);
  localparam int RATIO = C_M_DATA_WIDTH / C_S_DATA_WIDTH;
  localparam int OFF_W = $clog2(RATIO);
  localparam logic [OFF_W-1:0] LAST_LANE = OFF_W'(RATIO - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  // Handshake outputs are registered copies of the state decode so that
  // they are glitch-free and held low throughout reset.
  logic cmd_ready, m_rready, s_rvalid;

  logic [OFF_W-1:0] lane, lane_next;
  logic [7:0]       len, len_next;
  logic [7:0]       beat_cnt, cnt_next;
  logic             last_err, err_next;
  logic             capture;

  logic [RATIO-1:0][C_S_DATA_WIDTH-1:0] hold_data;
  logic [1:0]                           hold_resp;
  logic                                 hold_last;

  logic       s_last, s_hs, m_hs, needs_more;
  logic [8:0] remaining, lanes_left;

  assign s_last = s_rvalid && (beat_cnt == len);
  assign s_hs   = s_rvalid && bus.S_RREADY;
  assign m_hs   = m_rready && bus.M_RVALID;

  // A wide beat flagged last is premature when the narrow beats still owed
  // exceed the lanes left in that beat from the current lane onward.
  assign remaining  = {1'b0, len} - {1'b0, beat_cnt};
  assign lanes_left = 9'(RATIO - 1) - {{(9-OFF_W){1'b0}}, lane};
  assign needs_more = remaining > lanes_left;

  assign bus.CMD_READY = cmd_ready;
  assign bus.M_RREADY  = m_rready;
  assign bus.S_RVALID  = s_rvalid;
  assign bus.S_RDATA   = s_rvalid ? hold_data[lane] : '0;
  assign bus.S_RRESP   = s_rvalid ? hold_resp : '0;
  assign bus.S_RLAST   = s_last;
  assign bus.LAST_ERR  = last_err;

  // Next-state, lane/count sequencing and error detection
  always_comb begin
    state_next = state;
    lane_next  = lane;
    len_next   = len;
    cnt_next   = beat_cnt;
    err_next   = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.CMD_VALID && cmd_ready) begin
          lane_next  = bus.CMD_OFFSET;
          len_next   = bus.CMD_LEN;
          cnt_next   = '0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (m_hs) begin
          capture    = 1'b1;
          err_next   = bus.M_RLAST && needs_more;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (s_hs) begin
          cnt_next = beat_cnt + 8'd1;
          if (s_last) begin
            err_next   = !hold_last;
            state_next = IDLE;
          end else if (lane == LAST_LANE) begin
            lane_next  = '0;
            state_next = LOAD;
          end else begin
            lane_next = lane + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      m_rready  <= 1'b0;
      s_rvalid  <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_ready <= (state_next == IDLE);
      m_rready  <= (state_next == LOAD);
      s_rvalid  <= (state_next == DRAIN);
    end
  end

  // Burst bookkeeping and error pulse
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      lane     <= '0;
      len      <= '0;
      beat_cnt <= '0;
      last_err <= 1'b0;
    end else begin
      lane     <= lane_next;
      len      <= len_next;
      beat_cnt <= cnt_next;
      last_err <= err_next;
    end
  end

  // Wide-beat holding register
  always_ff @(posedge ACLK) begin
    if (capture) begin
      hold_data <= bus.M_RDATA;
      hold_resp <= bus.M_RRESP;
      hold_last <= bus.M_RLAST;
    end
  end
endmodule

// File: tb/tb_ddr4_v2_2_20_r_unpacker.sv
// Directed bench for the read unpacker at default widths (32 <- 128, 4 lanes).
module tb_ddr4_v2_2_20_r_unpacker;
  logic ACLK;
  logic ARESETN;

  int n_vec = 0;
  int n_err = 0;

  ddr4_v2_2_20_r_unpacker_if #(.C_S_DATA_WIDTH(32), .C_M_DATA_WIDTH(128)) bus ();

  ddr4_v2_2_20_r_unpacker #(
    .C_FAMILY       ("virtex6"),
    .C_S_DATA_WIDTH (32),
    .C_M_DATA_WIDTH (128)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Narrow word carried in lane k of wide beat w
  function automatic logic [31:0] lane_word(input int w, input int k);
    return 32'hC0DE_0000 | 32'(w << 8) | 32'(k);
  endfunction

  function automatic logic [127:0] wide_word(input int w);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[k*32 +: 32] = lane_word(w, k);
    return d;
  endfunction

  task automatic drive_wide(input int w, input int n_wide, input logic [63:0] last_mask,
                            input logic [1:0] resp);
    if (w < n_wide) begin
      bus.M_RVALID = 1'b1;
      bus.M_RDATA  = wide_word(w);
      bus.M_RLAST  = last_mask[w];
      bus.M_RRESP  = resp;
    end else begin
      bus.M_RVALID = 1'b0;
      bus.M_RDATA  = '0;
      bus.M_RLAST  = 1'b0;
      bus.M_RRESP  = '0;
    end
  endtask

  // One complete burst; n_wide is the hand-computed wide-beat count.
  task automatic run_burst(input string name, input int off, input int len, input int n_wide,
                           input logic [63:0] last_mask, input logic [1:0] resp,
                           input int stall_at, input int exp_err);
    int wide = 0, sbeats = 0, mhs = 0, errs = 0, cyc = 0, stall_left = 0, p;
    bit stalled = 0, prev_mhs = 0, m_hs, s_hs;
    logic [31:0] sv_data;
    logic [1:0]  sv_resp;
    logic        sv_last;

    bus.CMD_OFFSET = 2'(off);
    bus.CMD_LEN    = 8'(len);
    bus.CMD_VALID  = 1'b1;
    check_eq({name, "/cmd_ready"}, bus.CMD_READY, 1);
    @(posedge ACLK); #1;
    bus.CMD_VALID  = 1'b0;
    bus.S_RREADY   = 1'b1;
    drive_wide(0, n_wide, last_mask, resp);

    while (sbeats <= len && cyc < 3000) begin
      if (stall_left == 0 && !stalled && stall_at >= 0 && bus.S_RVALID && sbeats == stall_at) begin
        stalled    = 1;
        stall_left = 5;
        bus.S_RREADY = 1'b0;
        sv_data = bus.S_RDATA;
        sv_resp = bus.S_RRESP;
        sv_last = bus.S_RLAST;
        check_eq({name, "/stall_m_rready"}, bus.M_RREADY, 0);
      end else if (stall_left > 0) begin
        stall_left--;
        bus.S_RREADY = (stall_left == 0);
        check_eq({name, "/stall_data"}, bus.S_RDATA, sv_data);
        check_eq({name, "/stall_resp"}, bus.S_RRESP, sv_resp);
        check_eq({name, "/stall_last"}, bus.S_RLAST, sv_last);
        check_eq({name, "/stall_m_rready"}, bus.M_RREADY, 0);
      end

      s_hs = bus.S_RVALID && bus.S_RREADY;
      m_hs = bus.M_RVALID && bus.M_RREADY;
      if (prev_mhs) check_eq({name, "/first_s_latency"}, bus.S_RVALID, 1);
      if (s_hs) begin
        p = off + sbeats;
        check_eq($sformatf("%s/s_data[%0d]", name, sbeats), bus.S_RDATA, lane_word(p / 4, p % 4));
        check_eq($sformatf("%s/s_resp[%0d]", name, sbeats), bus.S_RRESP, resp);
        check_eq($sformatf("%s/s_last[%0d]", name, sbeats), bus.S_RLAST, (sbeats == len));
        sbeats++;
      end
      if (bus.LAST_ERR) errs++;
      if (m_hs) mhs++;
      prev_mhs = m_hs;

      @(posedge ACLK); #1;
      cyc++;
      if (m_hs) begin
        wide++;
        drive_wide(wide, n_wide, last_mask, resp);
      end
    end
    if (bus.LAST_ERR) errs++;

    check_eq({name, "/s_beats"}, sbeats, len + 1);
    check_eq({name, "/wide_beats"}, mhs, n_wide);
    check_eq({name, "/last_err"}, errs, exp_err);
    check_eq({name, "/idle_ready"}, bus.CMD_READY, 1);
    check_eq({name, "/idle_s_rvalid"}, bus.S_RVALID, 0);
    drive_wide(0, 0, '0, '0);
    @(posedge ACLK); #1;
    check_eq({name, "/err_clear"}, bus.LAST_ERR, 0);
  endtask

  initial begin
    ARESETN        = 1'b0;
    bus.CMD_VALID  = 1'b0;
    bus.CMD_OFFSET = '0;
    bus.CMD_LEN    = '0;
    bus.M_RDATA    = '0;
    bus.M_RRESP    = '0;
    bus.M_RLAST    = 1'b0;
    bus.M_RVALID   = 1'b0;
    bus.S_RREADY   = 1'b0;

    // Reset values
    repeat (3) @(posedge ACLK);
    #1;
    check_eq("rst/cmd_ready", bus.CMD_READY, 0);
    check_eq("rst/m_rready",  bus.M_RREADY, 0);
    check_eq("rst/s_rvalid",  bus.S_RVALID, 0);
    check_eq("rst/s_rlast",   bus.S_RLAST, 0);
    check_eq("rst/last_err",  bus.LAST_ERR, 0);
    #3 ARESETN = 1'b1;
    @(posedge ACLK); #1;
    check_eq("rel/cmd_ready", bus.CMD_READY, 1);

    // name, offset, len, wide beats, M_RLAST mask, resp, stall beat, LAST_ERR pulses
    run_burst("b8",      0,   7,  2, 64'h2, 2'b00, -1, 0);
    run_burst("off3",    3,   1,  2, 64'h2, 2'b00, -1, 0);
    run_burst("single",  2,   0,  1, 64'h1, 2'b10, -1, 0);
    run_burst("stall",   1,   9,  3, 64'h4, 2'b01,  2, 0);
    run_burst("early",   0,   7,  2, 64'h3, 2'b00, -1, 1);
    run_burst("nolast",  0,   3,  1, 64'h0, 2'b00, -1, 1);
    run_burst("len255",  0, 255, 64, 64'h8000_0000_0000_0000, 2'b11, -1, 0);

    // Reset while the third narrow beat is presented
    bus.CMD_OFFSET = 2'd0;
    bus.CMD_LEN    = 8'd7;
    bus.CMD_VALID  = 1'b1;
    @(posedge ACLK); #1;
    bus.CMD_VALID  = 1'b0;
    bus.S_RREADY   = 1'b1;
    drive_wide(0, 2, 64'h2, 2'b01);
    @(posedge ACLK); #1;
    drive_wide(0, 0, '0, '0);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    check_eq("mid/s_rvalid", bus.S_RVALID, 1);
    check_eq("mid/s_data",   bus.S_RDATA, lane_word(0, 2));
    ARESETN = 1'b0;
    #1;
    check_eq("midrst/s_rvalid",  bus.S_RVALID, 0);
    check_eq("midrst/s_rdata",   bus.S_RDATA, 0);
    check_eq("midrst/s_rresp",   bus.S_RRESP, 0);
    check_eq("midrst/s_rlast",   bus.S_RLAST, 0);
    check_eq("midrst/m_rready",  bus.M_RREADY, 0);
    check_eq("midrst/cmd_ready", bus.CMD_READY, 0);
    check_eq("midrst/last_err",  bus.LAST_ERR, 0);
    @(posedge ACLK); #3;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    check_eq("midrel/cmd_ready", bus.CMD_READY, 1);
    check_eq("midrel/s_rvalid",  bus.S_RVALID, 0);
    check_eq("midrel/m_rready",  bus.M_RREADY, 0);
    @(posedge ACLK); #1;
    check_eq("midrel/s_rvalid2", bus.S_RVALID, 0);
    run_burst("post_rst", 1, 2, 1, 64'h1, 2'b00, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
